// File: rtl/vga_tablero_render_pkg.sv
// buscaminas_pkg: shared types, colours, VGA timing and helpers for the board renderer.
//   cell_t      : packed board cell {revealed, flag, bomb, count[3:0]}
//   rgb_t       : packed 24-bit pixel colour {r, g, b}
//   count_rgb() : digit colour per neighbour count
//   tile_split(): pixel offset -> {tile index, offset inside tile} without a divider
package buscaminas_pkg;
    localparam int VGA_H_VIS  = 640;
    localparam int VGA_H_FP   = 16;
    localparam int VGA_H_SYNC = 96;
    localparam int VGA_H_BP   = 48;
    localparam int VGA_V_VIS  = 480;
    localparam int VGA_V_FP   = 10;
    localparam int VGA_V_SYNC = 2;
    localparam int VGA_V_BP   = 33;
    localparam int CELL_PX    = 50;
    localparam int BOARD_PX   = 8 * CELL_PX;
    localparam int X0         = 120;
    localparam int Y0         = 40;
    localparam logic [3:0] ST_VICTORIA = 4'd5;
    localparam logic [3:0] ST_DERROTA  = 4'd6;
    typedef struct packed {
        logic       revealed;
        logic       flag;
        logic       bomb;
        logic [3:0] count;
    } cell_t;
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;
    localparam rgb_t C_BLACK  = 24'h000000;
    localparam rgb_t C_WIN    = 24'h008000;
    localparam rgb_t C_LOSE   = 24'h800000;
    localparam rgb_t C_BG     = 24'h202020;
    localparam rgb_t C_CURSOR = 24'hFFFF00;
    localparam rgb_t C_GRID   = 24'h606060;
    localparam rgb_t C_FLAG   = 24'hFF0000;
    localparam rgb_t C_HIDDEN = 24'hC0C0C0;
    localparam rgb_t C_BOMB   = 24'hFF4040;
    localparam rgb_t C_OPEN   = 24'hE0E0E0;
    function automatic rgb_t count_rgb(input logic [3:0] n);
        case (n)
            4'd1:    return 24'h0000FF;
            4'd2:    return 24'h008000;
            4'd3:    return 24'hFF0000;
            4'd4:    return 24'h000080;
            4'd5:    return 24'h800000;
            4'd6:    return 24'h008080;
            4'd7:    return 24'h000000;
            4'd8:    return 24'h808080;
            default: return C_OPEN;
        endcase
    endfunction
    // Seven conditional subtractions cover offsets 0..399; result is {idx[2:0], rem[5:0]}.
    function automatic logic [8:0] tile_split(input logic [8:0] v);
        logic [8:0] rem;
        logic [2:0] idx;
        rem = v;
        idx = '0;
        for (int k = 0; k < 7; k++) begin
            if (rem >= 9'(CELL_PX)) begin
                rem = rem - 9'(CELL_PX);
                idx = idx + 3'd1;
            end
        end
        return {idx, rem[5:0]};
    endfunction
endpackage

// File: rtl/vga_tablero_render_if.sv
// vga_tablero_render_if: game-state inputs and VGA outputs of the board renderer.
//   tablero[8][8], i_actual, j_actual, state : board, cursor and game state (game -> renderer)
//   hsync, vsync, blank_n, r, g, b            : VGA signals (renderer -> display)
//   master: renderer side; slave: game/display side.
interface vga_tablero_render_if;
    import buscaminas_pkg::*;
    cell_t      tablero [8][8];
    logic [2:0] i_actual;
    logic [2:0] j_actual;
    logic [3:0] state;
    logic       hsync;
    logic       vsync;
    logic       blank_n;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    modport master (input tablero, i_actual, j_actual, state,
                    output hsync, vsync, blank_n, r, g, b);
    modport slave  (output tablero, i_actual, j_actual, state,
                    input hsync, vsync, blank_n, r, g, b);
endinterface

// File: rtl/vga_tablero_render_glyph.sv
// digit_glyph_rom: 5x7 bitmap font for digits 1..8.
//   digit : value to draw; anything outside 1..8 is never lit
//   row   : glyph row 0..6 (top first)
//   col   : glyph column 0..4 (left first)
//   lit   : pixel is part of the digit
module digit_glyph_rom (
    input  logic [3:0] digit,
    input  logic [2:0] row,
    input  logic [2:0] col,
    output logic       lit
);
    // Row 0 occupies the top five bits, leftmost column in the MSB of each row.
    localparam logic [34:0] FONT [8] = '{
        35'b00100_01100_00100_00100_00100_00100_01110,
        35'b01110_10001_00001_00010_00100_01000_11111,
        35'b11111_00010_00100_00010_00001_10001_01110,
        35'b00010_00110_01010_10010_11111_00010_00010,
        35'b11111_10000_11110_00001_00001_10001_01110,
        35'b00110_01000_10000_11110_10001_10001_01110,
        35'b11111_00001_00010_00100_01000_01000_01000,
        35'b01110_10001_10001_01110_10001_10001_01110
    };
    logic        w_ok;
    logic [34:0] w_bits;
    logic [5:0]  w_idx;
    always_comb begin
        w_ok   = (digit >= 4'd1) && (digit <= 4'd8) && (row <= 3'd6) && (col <= 3'd4);
        w_bits = FONT[3'(digit - 4'd1)];
        // Index is clamped when out of range so the read never goes past the bitmap.
        w_idx  = w_ok ? 6'd34 - (6'(row) * 6'd5 + 6'(col)) : 6'd0;
        lit    = w_ok && w_bits[w_idx];
    end
endmodule

// File: rtl/vga_tablero_render.sv
// vga_tablero_render: draws the 8x8 minesweeper board, cursor and game state as a VGA frame.
//   clk : pixel clock (25 MHz for 640x480@60)
//   rst : asynchronous, active-low reset
//   bus : master side of vga_tablero_render_if (board/cursor/state in, sync/blank/RGB out)
// Two register stages: S1 decodes the counters into tile coordinates, S2 looks up the cell,
// picks the colour and registers it together with the delayed syncs.
module vga_tablero_render
    import buscaminas_pkg::*;
#(
    parameter int H_VIS  = VGA_H_VIS,
    parameter int H_FP   = VGA_H_FP,
    parameter int H_SYNC = VGA_H_SYNC,
    parameter int H_BP   = VGA_H_BP,
    parameter int V_VIS  = VGA_V_VIS,
    parameter int V_FP   = VGA_V_FP,
    parameter int V_SYNC = VGA_V_SYNC,
    parameter int V_BP   = VGA_V_BP
) (
    input logic                  clk,
    input logic                  rst,
    vga_tablero_render_if.master bus
);
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    logic [9:0] r_hc, r_vc;
    logic       r1_vis, r1_hs, r1_vs, r1_in;
    logic [2:0] r1_row, r1_col;
    logic [5:0] r1_px, r1_py;
    logic       w_hs, w_vs, w_vis, w_in;
    logic [8:0] w_xo, w_yo, w_xs, w_ys;
    cell_t      w_cell;
    logic       w_cursor, w_grid, w_tri, w_disc, w_gin, w_lit;
    logic [5:0] w_dx, w_dy;
    logic [10:0] w_d2;
    logic [2:0] w_grow, w_gcol;
    rgb_t       w_bg, w_rgb;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hc <= '0;
            r_vc <= '0;
        end else begin
            r_hc <= (r_hc == 10'(H_TOT - 1)) ? '0 : r_hc + 10'd1;
            if (r_hc == 10'(H_TOT - 1))
                r_vc <= (r_vc == 10'(V_TOT - 1)) ? '0 : r_vc + 10'd1;
        end
    end
    always_comb begin
        w_hs  = !((r_hc >= 10'(H_VIS + H_FP)) && (r_hc < 10'(H_VIS + H_FP + H_SYNC)));
        w_vs  = !((r_vc >= 10'(V_VIS + V_FP)) && (r_vc < 10'(V_VIS + V_FP + V_SYNC)));
        w_vis = (r_hc < 10'(H_VIS)) && (r_vc < 10'(V_VIS));
        w_in  = (r_hc >= 10'(X0)) && (r_hc < 10'(X0 + BOARD_PX)) &&
                (r_vc >= 10'(Y0)) && (r_vc < 10'(Y0 + BOARD_PX));
        // Offsets wrap outside the board; in_board masks them downstream.
        w_xo  = r_hc[8:0] - 9'(X0);
        w_yo  = r_vc[8:0] - 9'(Y0);
        w_xs  = tile_split(w_xo);
        w_ys  = tile_split(w_yo);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r1_vis <= 1'b0;
            r1_hs  <= 1'b1;
            r1_vs  <= 1'b1;
            r1_in  <= 1'b0;
            r1_row <= '0;
            r1_col <= '0;
            r1_px  <= '0;
            r1_py  <= '0;
        end else begin
            r1_vis <= w_vis;
            r1_hs  <= w_hs;
            r1_vs  <= w_vs;
            r1_in  <= w_in;
            r1_row <= w_ys[8:6];
            r1_col <= w_xs[8:6];
            r1_px  <= w_xs[5:0];
            r1_py  <= w_ys[5:0];
        end
    end
    digit_glyph_rom u_glyph (
        .digit (w_cell.count),
        .row   (w_grow),
        .col   (w_gcol),
        .lit   (w_lit)
    );
    always_comb begin
        w_cell   = bus.tablero[r1_row][r1_col];
        w_cursor = (r1_row == bus.i_actual) && (r1_col == bus.j_actual) &&
                   ((r1_px <= 6'd2) || (r1_px >= 6'd47) || (r1_py <= 6'd2) || (r1_py >= 6'd47));
        w_grid   = (r1_px == 6'd0) || (r1_py == 6'd0);
        w_dx     = (r1_px >= 6'd25) ? r1_px - 6'd25 : 6'd25 - r1_px;
        w_dy     = (r1_py >= 6'd25) ? r1_py - 6'd25 : 6'd25 - r1_py;
        // Flag pennant widens by one pixel every two rows from its apex at py=10.
        w_tri    = (r1_py >= 6'd10) && (r1_py <= 6'd40) && (w_dx <= ((r1_py - 6'd10) >> 1));
        w_d2     = 11'(w_dx) * 11'(w_dx) + 11'(w_dy) * 11'(w_dy);
        w_disc   = w_d2 <= 11'd225;
        w_gin    = (r1_px >= 6'd15) && (r1_px <= 6'd34) && (r1_py >= 6'd11) && (r1_py <= 6'd38);
        w_gcol   = 3'((r1_px - 6'd15) >> 2);
        w_grow   = 3'((r1_py - 6'd11) >> 2);
        w_bg     = (bus.state == ST_VICTORIA) ? C_WIN : (bus.state == ST_DERROTA) ? C_LOSE : C_BG;
        w_rgb    = !r1_vis              ? C_BLACK :
                   !r1_in               ? w_bg :
                   w_cursor             ? C_CURSOR :
                   w_grid               ? C_GRID :
                   !w_cell.revealed     ? ((w_cell.flag && w_tri) ? C_FLAG : C_HIDDEN) :
                   w_cell.bomb          ? (w_disc ? C_BLACK : C_BOMB) :
                   (w_gin && w_lit)     ? count_rgb(w_cell.count) : C_OPEN;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.hsync   <= 1'b1;
            bus.vsync   <= 1'b1;
            bus.blank_n <= 1'b0;
            bus.r       <= '0;
            bus.g       <= '0;
            bus.b       <= '0;
        end else begin
            bus.hsync   <= r1_hs;
            bus.vsync   <= r1_vs;
            bus.blank_n <= r1_vis;
            bus.r       <= w_rgb.r;
            bus.g       <= w_rgb.g;
            bus.b       <= w_rgb.b;
        end
    end
endmodule

// File: tb/tb_vga_tablero_render.sv
// tb_vga_tablero_render: scoreboard bench for the board renderer (pixels, syncs, reset).
module tb_vga_tablero_render;
    import buscaminas_pkg::*;
    typedef struct {
        string       tag;
        int unsigned cyc;
        int          sel;
        logic [23:0] exp;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int unsigned cyc;
    int          n_chk = 0;
    int          n_fail = 0;
    exp_t        q[$];
    always #5 clk = ~clk;
    vga_tablero_render_if bus ();
    vga_tablero_render_if bus2 ();
    vga_tablero_render dut (.clk(clk), .rst(rst), .bus(bus));
    vga_tablero_render #(.V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut_v (.clk(clk), .rst(rst), .bus(bus2));
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    function automatic logic [23:0] obs(input int sel);
        case (sel)
            0:       return {bus.r, bus.g, bus.b};
            1:       return 24'(bus.hsync);
            2:       return 24'(bus.blank_n);
            default: return 24'(bus2.vsync);
        endcase
    endfunction
    task automatic at(input string tag, input int unsigned c, input int sel, input logic [23:0] e);
        q.push_back('{tag, c, sel, e});
    endtask
    // Pixel (x,y) reaches the outputs two clocks after the counters hold it.
    task automatic pix(input string tag, input int x, input int y, input logic [23:0] e);
        at(tag, 32'(y * 800 + x + 2), 0, e);
    endtask
    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 100000) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            chk("drain_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask
    always @(posedge clk or negedge rst)
        if (!rst) cyc <= 0;
        else cyc <= cyc + 1;
    always @(negedge clk) begin
        if (rst && q.size() > 0) begin
            if (cyc == q[0].cyc) begin
                chk(q[0].tag, 32'(obs(q[0].sel)), 32'(q[0].exp));
                void'(q.pop_front());
            end else if (cyc > q[0].cyc) begin
                chk({q[0].tag, "_missed"}, cyc, q[0].cyc);
                void'(q.pop_front());
            end
        end
    end
    initial begin
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                bus.tablero[i][j]  = '0;
                bus2.tablero[i][j] = '0;
            end
        bus.state = ST_DERROTA;
        bus.i_actual = 3'd7;
        bus.j_actual = 3'd0;
        bus2.state = 4'd0;
        bus2.i_actual = 3'd0;
        bus2.j_actual = 3'd0;
        bus.tablero[0][0] = 7'h40;
        bus.tablero[0][1] = 7'h43;
        bus.tablero[0][2] = 7'h41;
        bus.tablero[0][4] = 7'h4F;
        bus.tablero[0][7] = 7'h20;
        repeat (5) @(negedge clk);
        chk("rst_hsync", 32'(bus.hsync), 32'd1);
        chk("rst_vsync", 32'(bus.vsync), 32'd1);
        chk("rst_blank", 32'(bus.blank_n), 32'd0);
        chk("rst_rgb", 32'({bus.r, bus.g, bus.b}), 32'd0);
        chk("rst_vsync2", 32'(bus2.vsync), 32'd1);
        rst = 1'b1;
        at("blank_c1", 1, 2, 24'd0);
        at("blank_c2", 2, 2, 24'd1);
        at("blank_c641", 641, 2, 24'd1);
        at("blank_c642", 642, 2, 24'd0);
        at("hs_c657", 657, 1, 24'd1);
        at("hs_c658", 658, 1, 24'd0);
        at("hs_c753", 753, 1, 24'd0);
        at("hs_c754", 754, 1, 24'd1);
        at("hs_c1457", 1457, 1, 24'd1);
        at("hs_c1458", 1458, 1, 24'd0);
        at("vs_c4001", 4001, 3, 24'd1);
        at("vs_c4002", 4002, 3, 24'd0);
        at("vs_c5601", 5601, 3, 24'd0);
        at("vs_c5602", 5602, 3, 24'd1);
        pix("bg_derrota", 10, 10, 24'h800000);
        drain();
        bus.state = ST_VICTORIA;
        pix("bg_victoria", 600, 10, 24'h008000);
        drain();
        bus.state = 4'd0;
        pix("bg_other", 10, 11, 24'h202020);
        at("vs_c10401", 10401, 3, 24'd1);
        at("vs_c10402", 10402, 3, 24'd0);
        pix("hblank_black", 650, 20, 24'h000000);
        pix("flag_outside", 475, 45, 24'hC0C0C0);
        pix("grid_line", 170, 53, 24'h606060);
        pix("glyph3_lit", 187, 53, 24'hFF0000);
        pix("glyph1_lit", 245, 53, 24'h0000FF);
        pix("count15_plain", 345, 53, 24'hE0E0E0);
        pix("glyph3_unlit", 187, 55, 24'hE0E0E0);
        pix("open_zero", 145, 65, 24'hE0E0E0);
        pix("hidden", 295, 65, 24'hC0C0C0);
        pix("flag_centre", 495, 65, 24'hFF0000);
        drain();
        bus.tablero[0][7] = 7'h50;
        pix("bomb_centre", 495, 66, 24'h000000);
        pix("bomb_corner", 472, 87, 24'hFF4040);
        drain();
        bus.i_actual = 3'd1;
        bus.j_actual = 3'd5;
        pix("cursor_left", 321, 91, 24'hC0C0C0);
        pix("cursor_on", 371, 91, 24'hFFFF00);
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
